pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage core. It drives the per-stage `stall`/`flush` controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers from four event sources: load-use hazards, EX-stage redirects, multi-cycle data-memory waits, and an external halt request. It also owns a memory-wait watchdog and a stall-cycle performance counter. It sits beside the decode stage and is the only driver of the pipeline-register control inputs.

## Interface
- `TIMEOUT_CYCLES`, default 255: consecutive memory-wait stall cycles that trip the watchdog (≥2).
- `WAIT_CNT_WIDTH`, default 8: watchdog counter width; must hold `TIMEOUT_CYCLES`.
- `PERF_WIDTH`, default 32: width of `stall_cnt`.
- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  reset; one clock, reset asynchronous and active-low.
- `id_reg1_raddr`, `id_reg2_raddr`  in  `REG_ADDR_WIDTH` each  source register addresses of the instruction in ID.
- `id_reg1_ren`, `id_reg2_ren`  in  1 each  source register actually read.
- `id_ex_reg_waddr`  in  `REG_ADDR_WIDTH`  destination of the instruction in EX.
- `id_ex_reg_wen`  in  1  EX instruction writes a register.
- `id_ex_is_load`  in  1  EX instruction's writeback source is memory.
- `ex_redirect`  in  1  branch taken or jump resolved in EX this cycle.
- `mem_req`  in  1  MEM stage has an active data-memory access.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `halt_req`  in  1  debug/system halt request, level.
- `pc_stall`, `if_id_stall`, `id_ex_stall`, `ex_mem_stall`  out  1 each  hold the corresponding register.
- `if_id_flush`, `id_ex_flush`  out  1 each  load a bubble.
- `halted`  out  1  core is in HALT.
- `mem_timeout`  out  1  sticky watchdog error.
- `stall_cnt`  out  `PERF_WIDTH`  cycles with `pc_stall`=1, saturating.

## Operation
- **State machine:** RUN, MEM_WAIT, HALT, ERR. Outputs are combinational from state plus inputs. Priority within RUN: memory wait > redirect > load-use > halt.
- **Load-use hazard (`lu`):** `id_ex_is_load & id_ex_reg_wen & (id_ex_reg_waddr!=0) & ((id_reg1_ren & id_reg1_raddr==id_ex_reg_waddr) | (id_reg2_ren & id_reg2_raddr==id_ex_reg_waddr))`.
- **Memory stall (`mw`):** `mem_req & ~mem_ready`.
- **RUN:**
  - If `mw`: all four stalls = 1, flushes = 0; go to MEM_WAIT. A redirect is deferred; the EX instruction is held, so it re-asserts `ex_redirect` later.
  - Else if `ex_redirect`: `if_id_flush` = 1 and `id_ex_flush` = 1, no stalls, `lu` ignored.
  - Else if `lu`: `pc_stall` = 1, `if_id_stall` = 1, `id_ex_flush` = 1. This inserts exactly one bubble.
  - Else if `halt_req`: HALT outputs this cycle; go to HALT.
  - Otherwise all outputs are 0.
- **MEM_WAIT:** all stalls = `~mem_ready`. When `mem_ready` is 1, return to RUN and release in that same cycle, with no flush.
- **HALT:** `pc_stall` = 1, `if_id_stall` = 1, `id_ex_flush` = 1, so the back end drains. When `halt_req` is 0, return to RUN; outputs become RUN-evaluated that cycle. A redirect or `mw` in HALT is handled per the RUN rules without leaving HALT, with `mw` taking precedence.
- **Watchdog:** `wait_cnt` increments on every cycle with `ex_mem_stall` = 1 and clears on any cycle without it.
  - On the edge ending the `TIMEOUT_CYCLES`-th consecutive stall cycle, go to ERR.
- **ERR:** all stalls = 1, flushes = 0, `mem_timeout` = 1. ERR is left only by reset.
- **Invariant:** `id_ex_stall` and `id_ex_flush` are never both 1. The ID/EX register gives stall priority, so a violation would lose the bubble.
- **Counter:** `stall_cnt` increments when `pc_stall` is 1 and saturates at all-ones.

## Timing
- **Reset asserted (asynchronous):** state = RUN, `wait_cnt` = 0, `stall_cnt` = 0, `mem_timeout` = 0, `halted` = 0, all stalls = 0.
  - `if_id_flush` and `id_ex_flush` are forced to 1 while `rst_n` = 0, which clears the unreset pipeline registers.
  - Deassertion takes effect at the next rising edge.
- **Latency:** zero-cycle. Controls act at the same edge as the triggering event.
  - A load-use stall lasts exactly 1 cycle; the following cycle `lu` is 0 because a bubble is in EX.
- **`halted`:** 1 from the cycle after HALT entry until the cycle `halt_req` falls.
- **Reset mid-MEM_WAIT or mid-HALT:** state returns to RUN immediately and the counter clears.
- **`mem_req` with `mem_ready` in the same cycle:** no stall.

## Test plan
- **Load-use:** EX = load x5, ID reads x5 via rs2 → one cycle with `pc_stall` = `if_id_stall` = `id_ex_flush` = 1, then all 0; `stall_cnt` = 1.
- **x0 and unused operand:** EX = load x0 with ID reading x0 → no stall. `id_reg1_ren` = 0 with an address match → no stall.
- **Redirect over load-use:** `ex_redirect` and `lu` together → both flushes = 1, no stalls, no bubble cycle following.
- **Memory wait:** `mem_req` = 1, `mem_ready` low for 3 cycles then high → all stalls high for 3 cycles, released in the ready cycle; state back to RUN.
- **Watchdog:** `TIMEOUT_CYCLES` = 4, `mem_ready` held 0 → `mem_timeout` = 1 after the 4th stall cycle and stays 1 after `mem_ready` = 1, until `rst_n` pulses low.
- **Halt:** `halt_req` high for 5 cycles → `pc_stall` = 1 and `id_ex_flush` = 1 for 5 cycles, `halted` high cycles 2–5. Reset asserted mid-halt clears `halted` asynchronously.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage core.
// Arbitrates load-use hazards, EX redirects, data-memory waits and halt
// requests into per-stage stall/flush controls. It also runs a memory-wait
// watchdog and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned WAIT_CNT_WIDTH = 8,
  parameter int unsigned PERF_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] id_reg1_raddr,
  input  logic [REG_ADDR_WIDTH-1:0] id_reg2_raddr,
  input  logic                      id_reg1_ren,
  input  logic                      id_reg2_ren,
  input  logic [REG_ADDR_WIDTH-1:0] id_ex_reg_waddr,
  input  logic                      id_ex_reg_wen,
  input  logic                      id_ex_is_load,
  input  logic                      ex_redirect,
  input  logic                      mem_req,
  input  logic                      mem_ready,
  input  logic                      halt_req,
  output logic                      pc_stall,
  output logic                      if_id_stall,
  output logic                      id_ex_stall,
  output logic                      ex_mem_stall,
  output logic                      if_id_flush,
  output logic                      id_ex_flush,
  output logic                      halted,
  output logic                      mem_timeout,
  output logic [PERF_WIDTH-1:0]     stall_cnt
);

  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_TRIP = WAIT_CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [PERF_WIDTH-1:0]     PERF_MAX  = {PERF_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2,
    ST_ERR      = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
  logic [PERF_WIDTH-1:0]     stall_cnt_q, stall_cnt_d;
  logic                      lu_c;
  logic                      mw_c;

  // Hazard detection on the current ID/EX contents.
  assign lu_c = id_ex_is_load & id_ex_reg_wen & (id_ex_reg_waddr != '0) &
                ((id_reg1_ren & (id_reg1_raddr == id_ex_reg_waddr)) |
                 (id_reg2_ren & (id_reg2_raddr == id_ex_reg_waddr)));
  assign mw_c = mem_req & ~mem_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the watchdog trip overrides every other transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN, ST_HALT: begin
        if (state_q == ST_HALT && halt_req) begin
          state_d = ST_HALT;
        end else if (mw_c) begin
          state_d = ST_MEM_WAIT;
        end else if (!ex_redirect && !lu_c && halt_req) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_d = ST_RUN;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    if (state_q != ST_ERR && ex_mem_stall && wait_cnt_q == WAIT_TRIP) begin
      state_d = ST_ERR;
    end
  end

  // Stall/flush outputs; RUN and HALT share one arbitration since a held
  // halt request produces the same bubble pattern as a load-use hazard.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    unique case (state_q)
      ST_RUN, ST_HALT: begin
        if (mw_c) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_stall  = 1'b1;
          ex_mem_stall = 1'b1;
        end else if (ex_redirect) begin
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
        end else if (lu_c || halt_req) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_flush  = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        pc_stall     = ~mem_ready;
        if_id_stall  = ~mem_ready;
        id_ex_stall  = ~mem_ready;
        ex_mem_stall = ~mem_ready;
      end
      ST_ERR: begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
      end
      default: begin
        pc_stall     = 1'b0;
      end
    endcase
    // Reset drains the unreset pipeline registers with bubbles.
    if (!rst_n) begin
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      id_ex_stall  = 1'b0;
      ex_mem_stall = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end
  end

  // Watchdog run length and saturating stall counter next values.
  always_comb begin
    wait_cnt_d  = wait_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (state_q != ST_ERR) begin
      wait_cnt_d = ex_mem_stall ? (wait_cnt_q + WAIT_CNT_WIDTH'(1)) : '0;
    end
    if (pc_stall && stall_cnt_q != PERF_MAX) begin
      stall_cnt_d = stall_cnt_q + PERF_WIDTH'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign halted      = (state_q == ST_HALT) & halt_req;
  assign mem_timeout = (state_q == ST_ERR);
  assign stall_cnt   = stall_cnt_q;

endmodule
